// File: rtl/piso_serializer_if.sv
// Parallel-in / serial-out handshake bundle: word input side plus serial output side.
// The master drives din/din_valid; the slave (serializer) drives everything else.
interface piso_serializer_if #(
  parameter int WIDTH = 8
) ();

  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             sout;
  logic             sout_valid;
  logic             sout_last;
  logic             busy;

  modport master (
    output din,
    output din_valid,
    input  din_ready,
    input  sout,
    input  sout_valid,
    input  sout_last,
    input  busy
  );

  modport slave (
    input  din,
    input  din_valid,
    output din_ready,
    output sout,
    output sout_valid,
    output sout_last,
    output busy
  );

endinterface

// File: rtl/piso_serializer.sv
// MSB-first word serializer: MSB on sout one cycle after the accepting edge, WIDTH bits per word.
// Backpressure: din_ready only in IDLE or on the last-bit cycle, which allows gapless back-to-back words.
module piso_serializer #(
  parameter int WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  piso_serializer_if.slave     bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic in_shift;
  logic last_bit;
  logic ready;
  logic xfer;

  assign in_shift = (state_q == SHIFT);
  assign last_bit = in_shift && (cnt_q == LAST_CNT);
  assign ready    = !in_shift || last_bit;
  assign xfer     = bus.din_valid && ready;

  assign bus.din_ready  = ready;
  assign bus.sout       = in_shift && shreg_q[WIDTH-1];
  assign bus.sout_valid = in_shift;
  assign bus.sout_last  = last_bit;
  assign bus.busy       = in_shift;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          state_d = SHIFT;
          shreg_d = bus.din;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (last_bit) begin
          // A word accepted on the last bit reloads in place, so no gap cycle appears.
          if (xfer) begin
            shreg_d = bus.din;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
            shreg_d = '0;
            cnt_d   = '0;
          end
        end else begin
          shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        shreg_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (cnt_q <= LAST_CNT)
        else $error("bit counter beyond last bit position");
    end
  end

endmodule
